fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the decoder. It holds the PC and issues sequential word requests to instruction memory over a valid/ready request channel. In-order responses are buffered in a small queue and handed to decode as {instr, pc} under valid/ready. Redirects from execute (branch/jump) flush the queue and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
QDEPTH, 2, instruction queue entries; power of two, >= 2.
MAX_OUTSTANDING, 2, max imem requests in flight; must be <= QDEPTH.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address (byte address, [1:0]=0)
imem_rsp_valid  in  1  response valid; in request order, no backpressure, latency >= 1
imem_rsp_data  in  32  instruction word
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode accepts head
out_instr  out  32  instruction word to decode
out_pc  out  32  PC of out_instr
out_misalign  out  1  head is a misaligned-target fault (feature only; else tied 0)

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, queue empty, inflight=0, drop_cnt=0, halted=0. Outputs: imem_req_valid=0, out_valid=0, out_misalign=0, out_instr=0, out_pc=0.
- Issue: imem_req_valid=1 iff !halted && !redirect_valid && inflight + occupancy < QDEPTH && inflight < MAX_OUTSTANDING. imem_req_addr=pc. On handshake pc<=pc+4 (mod 2^32 wrap), inflight++.
- Each response: inflight--. If drop_cnt>0: discard, drop_cnt--. Else write {data, pc_of_request} to queue tail; the request PC travels in a QDEPTH-entry PC FIFO pushed at request handshake.
- Queue guaranteed never to overflow (issue rule); assertion if write while full.
- Output: out_valid = queue non-empty; head visible the cycle after the response is written. Pop on out_valid && out_ready. Simultaneous push and pop when full is legal.
- Minimum latency: request handshake cycle T, response cycle T+L, out_valid at T+L+1.
- Redirect (highest priority): queue and PC FIFO cleared, pc<=redirect_pc, drop_cnt<=inflight (+1 if no response in that cycle... precisely: drop_cnt <= inflight after this cycle's handshakes/responses are counted). A pop in the same cycle is void. No request issued in the redirect cycle; first new request next cycle. imem_req_valid dropping while !ready is permitted only on redirect.
- Redirect while drop_cnt>0 accumulates correctly (drop_cnt = total inflight).
- Without feature: redirect_pc[1:0] ignored (forced 00).

Optional Feature:
IF_MISALIGN_TRAP_EN
- Defined: redirect with redirect_pc[1:0]!=0 sets halted=1 (no requests). Once drop_cnt==0, out_valid=1, out_misalign=1, out_pc=redirect_pc, out_instr=32'h0000_0013; held until next redirect (pop ignored). Aligned redirect clears halted.
- Undefined: out_misalign constant 0, halted never set, low bits masked.

Decomposition:
- Package riscv_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, DEFAULT_RESET_PC, ILEN=32.
- Sub-module fetch_queue: sync FIFO {instr, pc}, parameter QDEPTH, push/pop/flush, full/empty/count. Instantiated once; PC FIFO may reuse it.

Test Plan:
- Reset, memory latency 1, out_ready=1 -> out_pc 0x0,0x4,0x8... one per cycle after warm-up; first out_valid 2 cycles after first handshake.
- out_ready=0 for 10 cycles -> exactly QDEPTH entries queued, imem_req_valid=0, no loss; release -> order preserved.
- Latency 3, 2 outstanding, redirect_pc=0x100 -> both stale responses dropped; next out_pc=0x100, then 0x104.
- Redirect same cycle as request handshake to 0x40 -> that response dropped, next request addr 0x40.
- imem_req_ready toggling randomly, PC at 0xFFFF_FFFC -> next out_pc wraps to 0x0.
- IF_MISALIGN_TRAP_EN, redirect_pc=0x102 -> no requests, out_misalign=1, out_pc=0x102, out_instr=0x13 held; redirect 0x200 clears it.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side constants and the queue entry layout.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {instr, pc} entries with flush; QDEPTH must be a power of two.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full/count exposed to the producer; push while full is only legal with a same-cycle pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_dat,
    input  logic                    pop,
    output fetch_entry_t            head_dat,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(QDEPTH):0] count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [QDEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(QDEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, imem request issue, in-order response queue to decode; redirect flushes.
// Latency: request accepted in T, response in T+L, instruction offered to decode in T+L+1.
// Backpressure: issue is throttled so inflight + queued never exceeds QDEPTH; optional IF_MISALIGN_TRAP_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int              QDEPTH          = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_misalign
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_tgt;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   pcq_count;
    logic [SW-1:0]   budget;
    logic            halted;
    logic            req_hs;
    logic            rsp_keep;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic            pcq_full;
    logic            pcq_empty;
    fetch_entry_t    q_head;
    fetch_entry_t    q_wdat;
    fetch_entry_t    pcq_head;
    fetch_entry_t    pcq_wdat;
    logic            unused_sigs;

    // Stale responses still occupy inflight slots, so they are budgeted too.
    assign budget         = SW'(inflight) + SW'(q_count);
    assign imem_req_valid = rst_n && !halted && !redirect_valid
                            && (budget < SW'(QDEPTH)) && (inflight < CW'(MAX_OUTSTANDING));
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0);
    assign pop            = out_valid && out_ready && !halted && !redirect_valid;
    assign q_wdat         = '{instr: imem_rsp_data, pc: pcq_head.pc};
    assign pcq_wdat       = '{instr: '0, pc: pc};

    fetch_queue #(.QDEPTH(QDEPTH)) u_pc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (req_hs),
        .push_dat (pcq_wdat),
        .pop      (rsp_keep),
        .head_dat (pcq_head),
        .full     (pcq_full),
        .empty    (pcq_empty),
        .count    (pcq_count)
    );

    fetch_queue #(.QDEPTH(QDEPTH)) u_instr_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (rsp_keep),
        .push_dat (q_wdat),
        .pop      (pop),
        .head_dat (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_comb begin
        inflight_nxt = inflight;
        if (req_hs && !imem_rsp_valid)      inflight_nxt = inflight + CW'(1);
        else if (!req_hs && imem_rsp_valid) inflight_nxt = inflight - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_nxt;
            // Everything still in flight after a redirect belongs to the old stream.
            if (redirect_valid)
                drop_cnt <= inflight_nxt;
            else if (imem_rsp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - CW'(1);
            if (redirect_valid)
                pc <= redirect_tgt;
            else if (req_hs)
                pc <= pc + 32'd4;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic [XLEN-1:0] trap_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            trap_pc <= '0;
        end else if (redirect_valid) begin
            halted  <= (redirect_pc[1:0] != 2'b00);
            trap_pc <= redirect_pc;
        end
    end

    assign redirect_tgt = redirect_pc;
`else
    assign halted       = 1'b0;
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    always_comb begin
        out_valid    = !q_empty;
        out_misalign = 1'b0;
        out_instr    = q_empty ? '0 : q_head.instr;
        out_pc       = q_empty ? '0 : q_head.pc;
`ifdef IF_MISALIGN_TRAP_EN
        // The fault is reported only once the old stream has fully drained.
        if (halted) begin
            out_valid    = (drop_cnt == '0);
            out_misalign = out_valid;
            out_instr    = out_valid ? NOP_INSTR : '0;
            out_pc       = out_valid ? trap_pc : '0;
        end
`endif
    end

    assign unused_sigs = ^{pcq_head.instr, pcq_count, pcq_full, pcq_empty, q_full, redirect_pc[1:0]};
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a request/response scoreboard model.
`timescale 1ns/1ps
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int QDEPTH  = 2;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misalign;

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_misalign   (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: every accepted request is remembered until its response;
    // a redirect marks all of them stale and empties the decode-visible queue.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } req_t;

    req_t        outst[$];
    logic [31:0] expq_pc[$];
    logic [31:0] expq_instr[$];
    logic [31:0] memq_addr[$];
    int          memq_due[$];
    logic [31:0] m_pc;
    bit          m_halted;
    logic [31:0] m_trap_pc;
    int          cyc, last_due;
    int          lat_min, lat_max, rdy_pct, ordy_pct;
    bit          redir_go;
    logic [31:0] redir_tgt;
    bit          popped, hs_seen;
    logic [31:0] last_pop_pc, last_hs_addr;
    int          first_hs, first_ov;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    task automatic step();
        bit   rsp, hs, exp_req, exp_ov, exp_mis, pop;
        int   lat;
        req_t r;
        redirect_valid = redir_go;
        redirect_pc    = redir_tgt;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ordy_pct);
        rsp            = (memq_due.size() > 0) && (memq_due[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(memq_addr[0]) : $urandom;
        @(negedge clk);
        exp_req = !m_halted && !redir_go && (outst.size() + expq_pc.size() < QDEPTH)
                  && (outst.size() < MAX_OUT);
        exp_ov  = m_halted ? (outst.size() == 0) : (expq_pc.size() > 0);
        exp_mis = m_halted && exp_ov;
        check("req_valid", imem_req_valid, exp_req);
        check("out_valid", out_valid, exp_ov);
        check("out_misalign", out_misalign, exp_mis);
        if (exp_ov && m_halted) begin
            check("trap_pc", out_pc, m_trap_pc);
            check("trap_instr", out_instr, NOP_INSTR);
        end else if (exp_ov) begin
            check("out_pc", out_pc, expq_pc[0]);
            check("out_instr", out_instr, expq_instr[0]);
        end
        if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
        hs  = (imem_req_valid === 1'b1) && imem_req_ready;
        pop = exp_ov && !m_halted && out_ready && !redir_go;
        if (pop) begin
            last_pop_pc = out_pc;
            popped = 1;
            void'(expq_pc.pop_front());
            void'(expq_instr.pop_front());
        end
        if (rsp) begin
            void'(memq_due.pop_front());
            void'(memq_addr.pop_front());
            r = outst.pop_front();
            if (!r.stale) begin
                expq_pc.push_back(r.pc);
                expq_instr.push_back(mem_word(r.pc));
            end
        end
        if (hs) begin
            check("req_addr", imem_req_addr, m_pc);
            hs_seen = 1;
            last_hs_addr = imem_req_addr;
            if (first_hs < 0) first_hs = cyc;
            lat = $urandom_range(lat_max, lat_min);
            memq_due.push_back((cyc + lat > last_due) ? cyc + lat : last_due + 1);
            last_due = memq_due[$];
            memq_addr.push_back(m_pc);
            outst.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir_go) begin
            foreach (outst[i]) outst[i].stale = 1'b1;
            expq_pc.delete();
            expq_instr.delete();
`ifdef IF_MISALIGN_TRAP_EN
            m_halted  = (redir_tgt[1:0] != 2'b00);
            m_trap_pc = redir_tgt;
`endif
            m_pc = redir_tgt & 32'hFFFF_FFFC;
            redir_go = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir_go  = 1;
        redir_tgt = tgt;
        step();
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp, input int budget);
        popped = 0;
        for (int k = 0; k < budget && !popped; k++) step();
        check(tag, popped ? last_pop_pc : 32'hxxxx_xxxx, exp);
    endtask

    task automatic wait_hs(input int budget);
        hs_seen = 0;
        for (int k = 0; k < budget && !hs_seen; k++) step();
    endtask

    initial begin
        rst_n = 0; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; out_ready = 0;
        cyc = 0; last_due = 0; m_pc = 32'h0; m_halted = 0; m_trap_pc = 0;
        redir_go = 0; redir_tgt = 0; popped = 0; hs_seen = 0;
        last_pop_pc = 0; last_hs_addr = 0; first_hs = -1; first_ov = -1;
        lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_misalign", out_misalign, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Latency 1, decode always ready.
        run(30);
        check("first_out_latency", first_ov - first_hs, 2);

        // Decode stalls: queue fills to QDEPTH and issue stops.
        ordy_pct = 0;
        run(10);
        check("stall_out_valid", out_valid, 1);
        check("stall_req_valid", imem_req_valid, 0);
        ordy_pct = 100;
        run(10);

        // Two requests in flight at latency 3, then redirect.
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 50 && outst.size() < 2; k++) step();
        check("two_outstanding", outst.size(), 2);
        redirect_to(32'h100);
        wait_pop("redir_first", 32'h100, 50);
        wait_pop("redir_second", 32'h104, 50);

        // Redirect the cycle after a handshake: that response must be dropped.
        wait_hs(50);
        redirect_to(32'h40);
        wait_hs(50);
        check("redir_req_addr", hs_seen ? last_hs_addr : 32'hxxxx_xxxx, 32'h40);
        wait_pop("redir_pop_40", 32'h40, 50);

        // Address wrap under random ready and latency.
        rdy_pct = 50; ordy_pct = 70; lat_min = 1; lat_max = 4;
        redirect_to(32'hFFFF_FFF8);
        wait_pop("wrap_fff8", 32'hFFFF_FFF8, 200);
        wait_pop("wrap_fffc", 32'hFFFF_FFFC, 200);
        wait_pop("wrap_zero", 32'h0000_0000, 200);

`ifdef IF_MISALIGN_TRAP_EN
        redirect_to(32'h102);
        run(15);
        check("trap_misalign", out_misalign, 1);
        check("trap_hold_pc", out_pc, 32'h102);
        check("trap_hold_instr", out_instr, 32'h13);
        check("trap_no_req", imem_req_valid, 0);
        redirect_to(32'h200);
        wait_pop("trap_clear", 32'h200, 200);
`else
        redirect_to(32'h203);
        wait_pop("masked_low_bits", 32'h200, 200);
`endif

        // Random traffic with occasional redirects, including back-to-back drops.
        for (int seg = 0; seg < 10; seg++) begin
            rdy_pct  = $urandom_range(100, 30);
            ordy_pct = $urandom_range(100, 20);
            lat_min  = 1;
            lat_max  = $urandom_range(5, 1);
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(99) < 4) begin
                    redir_go  = 1;
                    redir_tgt = $urandom;
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
